// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, stage bundle layout and width helper for pipeline stage buffers
package pipe_pkg;

    localparam int XLEN = 32;
    localparam int REG_W = 5;
    localparam logic [XLEN-1:0] ZERO_WORD = '0;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // Stage bundle layout, LSB first: rd, funct3, reg_src, control bits.
    localparam int F3_W = 3;
    localparam int CTRL_W = 4;
    localparam int RD_LSB = 0;
    localparam int F3_LSB = RD_LSB + REG_W;
    localparam int SRC_LSB = F3_LSB + F3_W;
    localparam int CTRL_LSB = SRC_LSB + REG_W;
    localparam int BUNDLE_W = CTRL_LSB + CTRL_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  reg_src;
        logic [F3_W-1:0]   funct3;
        logic [REG_W-1:0]  rd;
    } stage_ctrl_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_ram.sv
// rtl/pipe_stage_ram.sv - DEPTH x WIDTH register array, one write port, one asynchronous read port
module pipe_stage_ram
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int AW    = width_of(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - DEPTH-entry elastic pipeline stage with stall, bubble flush and flush counter
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       stall,
    input  logic                       bubble,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int PTR_W = width_of(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = ((CNT_W > CW) ? CNT_W : CW) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [SW-1:0] FLUSH_MAX = SW'({CNT_W{1'b1}});

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [SW-1:0]    flush_sum;
    logic [WIDTH-1:0] rdata;
    logic             push;
    logic             pop;

    // No dependence on out_ready: a full stage never accepts in the same cycle it pops.
    assign in_ready  = rst_n && !stall && !bubble && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !stall && !bubble;
    assign flush_sum = SW'(flush_q) + SW'(count_q);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        flush_d  = flush_q;
        if (bubble) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            flush_d  = (flush_sum > FLUSH_MAX) ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flush_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flush_q  <= flush_d;
        end
    end

    pipe_stage_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign out_data  = out_valid ? rdata : DEFAULT_VAL;
    assign occupancy = count_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed and randomized checks of pipe_stage_buf against a queue model
module tb_pipe_stage_buf;

    localparam int          DEPTH   = 2;
    localparam int          CNT_W   = 2;
    localparam logic [31:0] DEF     = 32'hDEAD_BEEF;
    localparam int          SAT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        stall;
    logic        bubble;
    logic [1:0]  occupancy;
    logic [1:0]  flush_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mq[$];
    int          mflush = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .WIDTH       (32),
        .DEPTH       (DEPTH),
        .DEFAULT_VAL (DEF),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall     (stall),
        .bubble    (bubble),
        .occupancy (occupancy),
        .flush_cnt (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs();
        logic exp_rdy;
        if (!rst_n) begin
            mq.delete();
            mflush = 0;
        end
        exp_rdy = rst_n && !stall && !bubble && (mq.size() < DEPTH);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        chk("out_valid", {31'b0, out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
        chk("out_data", out_data, (mq.size() != 0) ? mq[0] : DEF);
        chk("occupancy", {30'b0, occupancy}, 32'(mq.size()));
        chk("flush_cnt", {30'b0, flush_cnt}, 32'(mflush));
    endtask

    task automatic update_model();
        bit do_push;
        bit do_pop;
        if (!rst_n) begin
            mq.delete();
            mflush = 0;
        end else if (bubble) begin
            mflush = mflush + mq.size();
            if (mflush > SAT_MAX) mflush = SAT_MAX;
            mq.delete();
        end else if (!stall) begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() != 0) && out_ready;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
        end
    endtask

    task automatic cyc(input logic rn, input logic v, input logic [31:0] d,
                       input logic r, input logic s, input logic b);
        @(negedge clk);
        rst_n     = rn;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        stall     = s;
        bubble    = b;
        #1;
        compare_outputs();
        @(posedge clk);
        update_model();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; bubble = 1'b0;

        cyc(0, 1, 32'h1234_5678, 1, 0, 0);
        cyc(0, 1, 32'h1234_5678, 1, 0, 0);
        cyc(1, 1, 32'hA5A5_A5A5, 0, 0, 0);
        #1 chk("a5_head", out_data, 32'hA5A5_A5A5);
        cyc(1, 0, 32'h0, 1, 0, 0);

        cyc(1, 1, 32'h11, 0, 0, 0);
        cyc(1, 1, 32'h22, 0, 0, 0);
        #1 chk("fill_occ", {30'b0, occupancy}, 32'd2);
        cyc(1, 1, 32'h33, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0);
        cyc(1, 0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 20; i++) cyc(1, 1, 32'h100 + 32'(i), 1, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0);

        cyc(1, 1, 32'h44, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h55, 1, 1, 0);
        #1 chk("stall_head", out_data, 32'h44);
        cyc(1, 1, 32'h55, 1, 0, 0);
        cyc(1, 1, 32'h66, 1, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0);

        cyc(1, 1, 32'h77, 0, 0, 0);
        cyc(1, 1, 32'h88, 0, 0, 0);
        cyc(1, 1, 32'h99, 1, 1, 1);
        #1;
        chk("bub_flush", {30'b0, flush_cnt}, 32'd2);
        chk("bub_occ", {30'b0, occupancy}, 32'd0);
        chk("bub_data", out_data, DEF);

        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 32'hC0 + 32'(k), 0, 0, 0);
            cyc(1, 1, 32'hD0 + 32'(k), 0, 0, 0);
            cyc(1, 0, 32'h0, 0, 0, 1);
        end
        #1 chk("sat_flush", {30'b0, flush_cnt}, 32'd3);
        cyc(1, 0, 32'h0, 0, 0, 1);

        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(99) != 0),
                ($urandom_range(9) < 7),
                $urandom,
                ($urandom_range(9) < 6),
                ($urandom_range(99) < 15),
                ($urandom_range(99) < 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
